// File: rtl/uart_pkg.sv
// Shared encodings and constants for the configurable UART transmitter
// and its matching receiver.
package uart_pkg;

  localparam int MIN_DATA_BITS        = 5;
  localparam int DEFAULT_CLKS_PER_BIT = 217;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Frame handshake between a host-side byte source and the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int MAX_DATA_BITS = 9
);
  logic [MAX_DATA_BITS-1:0] i_TX_Data;
  logic                     i_TX_DV;
  logic                     o_TX_Ready;

  modport master (output i_TX_Data, output i_TX_DV, input  o_TX_Ready);
  modport slave  (input  i_TX_Data, input  i_TX_DV, output o_TX_Ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..i_Last and strobes o_Bit_End on the final
// cycle of each bit. Shared with the receiver.
module uart_bit_timer #(
  parameter int CLK_CNT_W = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Clear,
  input  logic                 i_Run,
  input  logic [CLK_CNT_W-1:0] i_Last,
  output logic                 o_Bit_End
);

  logic [CLK_CNT_W-1:0] r_Cnt;

  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_Clear) begin
      r_Cnt <= '0;
    end else if (i_Run) begin
      r_Cnt <= (r_Cnt == i_Last) ? '0 : r_Cnt + 1'b1;
    end
  end

  assign o_Bit_End = i_Run && (r_Cnt == i_Last);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..9 data bits, none/even/odd parity,
// 1 or 2 stop bits, run-time baud divisor; frame settings latched on accept.
module uart_tx_cfg #(
  parameter int MAX_DATA_BITS        = 9,
  parameter int CLK_CNT_W            = 16,
  parameter int DEFAULT_CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  uart_tx_cfg_if.slave         s_tx,
  input  logic [CLK_CNT_W-1:0] i_Clks_Per_Bit,
  input  logic [3:0]           i_Data_Bits,
  input  logic [1:0]           i_Parity,
  input  logic                 i_Two_Stop,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Active,
  output logic                 o_TX_Done
);
  import uart_pkg::*;

  if (MAX_DATA_BITS < MIN_DATA_BITS || MAX_DATA_BITS > 9 ||
      DEFAULT_CLKS_PER_BIT < 1 || DEFAULT_CLKS_PER_BIT > 2**CLK_CNT_W - 1) begin : g_bad_cfg
    $error("uart_tx_cfg: parameter out of range");
  end

  function automatic logic [3:0] clamp_bits(input logic [3:0] d);
    if (d < 4'(MIN_DATA_BITS))      return 4'(MIN_DATA_BITS);
    else if (d > 4'(MAX_DATA_BITS)) return 4'(MAX_DATA_BITS);
    else                            return d;
  endfunction

  function automatic logic [MAX_DATA_BITS-1:0] data_mask(input logic [3:0] d);
    logic [MAX_DATA_BITS-1:0] m;
    for (int i = 0; i < MAX_DATA_BITS; i++) m[i] = (i < int'(d));
    return m;
  endfunction

  state_e                   r_State, w_State_Nxt;
  logic [MAX_DATA_BITS-1:0] r_Shift, w_Shift_Nxt;
  logic [CLK_CNT_W-1:0]     r_Last;
  logic [3:0]               r_Last_Bit, r_Bit_Idx, w_Bit_Idx_Nxt;
  logic                     r_Par_En, r_Par_Bit, r_Two_Stop;
  logic                     r_Stop_Idx, w_Stop_Idx_Nxt;
  logic                     r_Serial, r_Active, r_Done;
  logic                     w_Serial_Nxt, w_Done_Nxt;
  logic                     w_Accept, w_Bit_End;
  logic [3:0]               w_D;
  logic [MAX_DATA_BITS-1:0] w_Data_Masked;

  assign w_Accept      = s_tx.i_TX_DV && (r_State == IDLE) && !i_Reset;
  assign w_D           = clamp_bits(i_Data_Bits);
  assign w_Data_Masked = s_tx.i_TX_Data & data_mask(w_D);

  uart_bit_timer #(.CLK_CNT_W(CLK_CNT_W)) u_timer (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Clear   (w_Accept),
    .i_Run     (r_State != IDLE),
    .i_Last    (r_Last),
    .o_Bit_End (w_Bit_End)
  );

  always_comb begin
    w_State_Nxt    = r_State;
    w_Shift_Nxt    = r_Shift;
    w_Bit_Idx_Nxt  = r_Bit_Idx;
    w_Stop_Idx_Nxt = r_Stop_Idx;
    w_Done_Nxt     = 1'b0;
    w_Serial_Nxt   = 1'b1;
    unique case (r_State)
      IDLE: if (w_Accept) begin
        w_State_Nxt    = START;
        w_Shift_Nxt    = w_Data_Masked;
        w_Bit_Idx_Nxt  = '0;
        w_Stop_Idx_Nxt = 1'b0;
      end
      START: if (w_Bit_End) w_State_Nxt = DATA;
      DATA: if (w_Bit_End) begin
        if (r_Bit_Idx == r_Last_Bit) begin
          w_State_Nxt = r_Par_En ? PARITY : STOP;
        end else begin
          w_Bit_Idx_Nxt = r_Bit_Idx + 4'd1;
          w_Shift_Nxt   = r_Shift >> 1;
        end
      end
      PARITY: if (w_Bit_End) w_State_Nxt = STOP;
      STOP: if (w_Bit_End) begin
        if (r_Two_Stop && !r_Stop_Idx) begin
          w_Stop_Idx_Nxt = 1'b1;
        end else begin
          w_State_Nxt = IDLE;
          w_Done_Nxt  = 1'b1;
        end
      end
      default: w_State_Nxt = IDLE;
    endcase
    // Line level is registered from the state being entered
    unique case (w_State_Nxt)
      START:   w_Serial_Nxt = 1'b0;
      DATA:    w_Serial_Nxt = w_Shift_Nxt[0];
      PARITY:  w_Serial_Nxt = r_Par_Bit;
      default: w_Serial_Nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State    <= IDLE;
      r_Bit_Idx  <= '0;
      r_Stop_Idx <= 1'b0;
      r_Serial   <= 1'b1;
      r_Active   <= 1'b0;
      r_Done     <= 1'b0;
    end else begin
      r_State    <= w_State_Nxt;
      r_Bit_Idx  <= w_Bit_Idx_Nxt;
      r_Stop_Idx <= w_Stop_Idx_Nxt;
      r_Serial   <= w_Serial_Nxt;
      r_Active   <= (w_State_Nxt != IDLE);
      r_Done     <= w_Done_Nxt;
    end
  end

  always_ff @(posedge i_Clock) begin
    r_Shift <= w_Shift_Nxt;
    if (w_Accept) begin
      r_Last     <= (i_Clks_Per_Bit == '0) ? '0 : i_Clks_Per_Bit - 1'b1;
      r_Last_Bit <= w_D - 4'd1;
      r_Par_En   <= (i_Parity == PAR_EVEN) || (i_Parity == PAR_ODD);
      r_Par_Bit  <= (^w_Data_Masked) ^ (i_Parity == PAR_ODD);
      r_Two_Stop <= i_Two_Stop;
    end
  end

  assign s_tx.o_TX_Ready = (r_State == IDLE) && !i_Reset;
  assign o_TX_Serial     = r_Serial;
  assign o_TX_Active     = r_Active;
  assign o_TX_Done       = r_Done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: expected frames are hand-written bit strings
// (start, data LSB first, parity, stops) expanded to N cycles per bit.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpb;
  logic [3:0]  dbits;
  logic [1:0]  par;
  logic        two;
  logic        ser, act, done;
  int          n_checks = 0;
  int          n_pass   = 0;

  uart_tx_cfg_if #(.MAX_DATA_BITS(9)) tx();

  uart_tx_cfg #(.MAX_DATA_BITS(9), .CLK_CNT_W(16), .DEFAULT_CLKS_PER_BIT(217)) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .s_tx           (tx),
    .i_Clks_Per_Bit (cpb),
    .i_Data_Bits    (dbits),
    .i_Parity       (par),
    .i_Two_Stop     (two),
    .o_TX_Serial    (ser),
    .o_TX_Active    (act),
    .o_TX_Done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Sends one frame and checks line waveform, Active length, Done position.
  // At cycle chg_at (>0) the divisor and payload inputs are changed mid-frame.
  task automatic send_frame(input string tag, input int n, input int d,
                            input logic [1:0] p, input logic ts,
                            input logic [8:0] data, input string bits,
                            input int chg_at);
    int L, guard, bad, first_bad, act_cnt, done_at, dones;
    logic exp_b;
    L = n * bits.len();
    cpb = 16'(n); dbits = 4'(d); par = p; two = ts; tx.i_TX_Data = data;
    guard = 0;
    while (!tx.o_TX_Ready && guard < 500) begin tick(); guard++; end
    check({tag, " ready"}, int'(tx.o_TX_Ready), 1);
    tx.i_TX_DV = 1'b1;
    tick();
    tx.i_TX_DV = 1'b0;
    bad = 0; first_bad = 0; act_cnt = 0; done_at = 0; dones = 0;
    for (int c = 1; c <= L + 1; c++) begin
      if (c == chg_at) begin cpb = 16'd8; tx.i_TX_Data = '0; end
      exp_b = (c <= L) ? (bits[(c-1)/n] == "1") : 1'b1;
      if (ser !== exp_b || (c <= L && tx.o_TX_Ready)) begin
        bad++;
        if (first_bad == 0) first_bad = c;
      end
      if (act) act_cnt++;
      if (done) begin dones++; done_at = c; end
      if (c == L + 1) check({tag, " ready_at_done"}, int'(tx.o_TX_Ready), 1);
      tick();
    end
    check({tag, " wave_first_bad_cycle"}, first_bad, 0);
    check({tag, " active_cycles"}, act_cnt, L);
    check({tag, " done_cycle"}, done_at, L + 1);
    check({tag, " done_count"}, dones, 1);
    check({tag, " done_after"}, int'(done), 0);
  endtask

  initial begin
    int starts[$];
    int dones, viol, k, guard;
    logic acc, prev_act;
    logic [8:0] payloads [3];

    rst = 1'b1; cpb = 16'd4; dbits = 4'd8; par = 2'b00; two = 1'b0;
    tx.i_TX_Data = '0; tx.i_TX_DV = 1'b1;
    repeat (3) tick();
    check("rst serial", int'(ser), 1);
    check("rst active", int'(act), 0);
    check("rst done",   int'(done), 0);
    check("rst ready",  int'(tx.o_TX_Ready), 0);
    tx.i_TX_DV = 1'b0;
    rst = 1'b0;
    tick();

    // 8N1, N=4, 0xA5: L=40, Done at cycle 41
    send_frame("8n1_a5", 4, 8, 2'b00, 1'b0, 9'h0A5, "0101001011", 0);
    // 7E2 / 7O2, N=3, 0x13: L=33
    send_frame("7e2_13", 3, 7, 2'b01, 1'b1, 9'h013, "01100100111", 0);
    send_frame("7o2_13", 3, 7, 2'b10, 1'b1, 9'h013, "01100100011", 0);
    // 9 bits all ones, then 5 bits with upper payload bits ignored
    send_frame("9n1_1ff", 2, 9, 2'b00, 1'b0, 9'h1FF, "01111111111", 0);
    send_frame("5n1_3e0", 2, 5, 2'b00, 1'b0, 9'h3E0, "0000001", 0);
    // parity code 11 acts as none; out-of-range D clamps to 5
    send_frame("d2_p3",   2, 2, 2'b11, 1'b0, 9'h1F5, "0101011", 0);

    // Mid-frame config change: frame keeps N=4 and 0xA5; next frame uses N=8
    send_frame("chg_a5", 4, 8, 2'b00, 1'b0, 9'h0A5, "0101001011", 10);
    send_frame("n8_3c",  8, 8, 2'b00, 1'b0, 9'h03C, "0001111001", 0);

    // Back-to-back with DV held high
    payloads = '{9'h055, 9'h00F, 9'h0F0};
    cpb = 16'd4; dbits = 4'd8; par = 2'b00; two = 1'b0;
    k = 0; dones = 0; viol = 0; prev_act = act;
    tx.i_TX_Data = payloads[0]; tx.i_TX_DV = 1'b1;
    for (int c = 0; c < 200; c++) begin
      acc = tx.o_TX_Ready && tx.i_TX_DV;
      if (tx.o_TX_Ready === act) viol++;
      if (!prev_act && act) starts.push_back(c);
      prev_act = act;
      if (done) dones++;
      tick();
      if (acc) begin
        k++;
        if (k < 3) tx.i_TX_Data = payloads[k];
        else tx.i_TX_DV = 1'b0;
      end
    end
    check("b2b start_count", starts.size(), 3);
    check("b2b gap1", (starts.size() >= 2) ? starts[1] - starts[0] : -1, 41);
    check("b2b gap2", (starts.size() >= 3) ? starts[2] - starts[1] : -1, 41);
    check("b2b done_count", dones, 3);
    check("b2b ready_outside_idle", viol, 0);

    // Reset during data bit 3 (cycles 17..20 after accept)
    cpb = 16'd4; dbits = 4'd8; tx.i_TX_Data = 9'h0A5;
    guard = 0;
    while (!tx.o_TX_Ready && guard < 500) begin tick(); guard++; end
    tx.i_TX_DV = 1'b1;
    tick();
    tx.i_TX_DV = 1'b0;
    repeat (17) tick();
    check("abort active_before", int'(act), 1);
    check("abort line_bit3", int'(ser), 0);
    rst = 1'b1;
    #1;
    check("abort ready_in_rst", int'(tx.o_TX_Ready), 0);
    tick();
    check("abort serial", int'(ser), 1);
    check("abort active", int'(act), 0);
    check("abort done",   int'(done), 0);
    tick();
    rst = 1'b0;
    #1;
    check("abort ready_after", int'(tx.o_TX_Ready), 1);
    dones = 0; viol = 0;
    for (int c = 0; c < 45; c++) begin
      if (done) dones++;
      if (ser !== 1'b1 || act) viol++;
      tick();
    end
    check("abort no_done", dones, 0);
    check("abort idle_line", viol, 0);
    send_frame("post_rst", 4, 8, 2'b00, 1'b0, 9'h0A5, "0101001011", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
